// File: rtl/flag_stack_if.sv
// flag_stack bus: ALU flag update, stack control,
// and the registered flag/stack status returned to the sequencer.
interface flag_stack_if #(
   parameter int FLAG_W = 4,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
);
   logic [FLAG_W-1:0] flags_in;
   logic [FLAG_W-1:0] write_mask;
   logic              write_enable;
   logic              push;
   logic              pop;
   logic              err_clear;

   logic [FLAG_W-1:0] flags_out;
   logic              carry_out;
   logic              zero_out;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              overflow_err;
   logic              underflow_err;

   modport master (
      output flags_in,
      output write_mask,
      output write_enable,
      output push,
      output pop,
      output err_clear,
      input  flags_out,
      input  carry_out,
      input  zero_out,
      input  count,
      input  full,
      input  empty,
      input  overflow_err,
      input  underflow_err
   );

   modport slave (
      input  flags_in,
      input  write_mask,
      input  write_enable,
      input  push,
      input  pop,
      input  err_clear,
      output flags_out,
      output carry_out,
      output zero_out,
      output count,
      output full,
      output empty,
      output overflow_err,
      output underflow_err
   );
endinterface

// File: rtl/flag_stack.sv
// Status flag register with masked update and a LIFO
// save/restore stack for subroutine calls and interrupts.
module flag_stack #(
   parameter int FLAG_W = 4,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input logic         clk,
   input logic         bReset,
   flag_stack_if.slave bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [FLAG_W-1:0] flags_q;
   logic [FLAG_W-1:0] flags_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              ovf_q;
   logic              ovf_d;
   logic              unf_q;
   logic              unf_d;

   logic [FLAG_W-1:0] stack [DEPTH];

   logic              is_full;
   logic              is_empty;
   logic              do_push;
   logic              do_pop;
   logic              push_ok;
   logic              pop_ok;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic [FLAG_W-1:0] masked;

   assign is_full  = (cnt_q == CNT_W'(DEPTH));
   assign is_empty = (cnt_q == '0);

   // push together with pop cancels out as a save-then-restore
   assign do_push = bus.push & ~bus.pop;
   assign do_pop  = bus.pop & ~bus.push;
   assign push_ok = do_push & ~is_full;
   assign pop_ok  = do_pop & ~is_empty;

   assign wr_idx = IDX_W'(cnt_q);
   assign rd_idx = IDX_W'(cnt_q - CNT_W'(1));

   assign masked = (bus.flags_in & bus.write_mask)
                 | (flags_q & ~bus.write_mask);

   always_comb begin
      flags_d = flags_q;
      cnt_d   = cnt_q;
      if (pop_ok) begin
         flags_d = stack[rd_idx];
         cnt_d   = cnt_q - CNT_W'(1);
      end else begin
         if (bus.write_enable) begin
            flags_d = masked;
         end
         if (push_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // a new error in the clearing cycle keeps the bit set
   always_comb begin
      ovf_d = ovf_q & ~bus.err_clear;
      unf_d = unf_q & ~bus.err_clear;
      if (do_push && is_full) begin
         ovf_d = 1'b1;
      end
      if (do_pop && is_empty) begin
         unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (bReset) begin
         flags_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!bReset && push_ok) begin
         stack[wr_idx] <= flags_q;
      end
   end

   assign bus.flags_out     = flags_q;
   assign bus.carry_out     = flags_q[0];
   assign bus.zero_out      = flags_q[1];
   assign bus.count         = cnt_q;
   assign bus.full          = is_full;
   assign bus.empty         = is_empty;
   assign bus.overflow_err  = ovf_q;
   assign bus.underflow_err = unf_q;

endmodule

// File: tb/tb_flag_stack.sv
// Directed bench for flag_stack: stimulus queues expected
// state, a separate monitor compares after each edge.
module tb_flag_stack;

   logic clk;
   logic bReset;

   flag_stack_if #(.FLAG_W(4), .DEPTH(4)) bus ();

   flag_stack #(
      .FLAG_W(4),
      .DEPTH (4)
   ) dut (
      .clk   (clk),
      .bReset(bReset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0] flags;
      logic [2:0] cnt;
      logic       ovf;
      logic       unf;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [7:0] act,
                      input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t",
                  name, act, req, $time);
      end
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #2;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk("flags", 8'(bus.flags_out), 8'(e.flags));
         chk("count", 8'(bus.count), 8'(e.cnt));
         chk("full", 8'(bus.full), 8'(e.cnt == 3'd4));
         chk("empty", 8'(bus.empty), 8'(e.cnt == 3'd0));
         chk("carry", 8'(bus.carry_out), 8'(e.flags[0]));
         chk("zero", 8'(bus.zero_out), 8'(e.flags[1]));
         chk("ovf", 8'(bus.overflow_err), 8'(e.ovf));
         chk("unf", 8'(bus.underflow_err), 8'(e.unf));
      end
   end

   task automatic step(input logic       rst,
                       input logic       we,
                       input logic [3:0] mask,
                       input logic [3:0] fin,
                       input logic       ps,
                       input logic       pp,
                       input logic       clr,
                       input logic [3:0] ef,
                       input logic [2:0] ec,
                       input logic       eo,
                       input logic       eu);
      exp_t e;
      @(negedge clk);
      bReset           = rst;
      bus.write_enable = we;
      bus.write_mask   = mask;
      bus.flags_in     = fin;
      bus.push         = ps;
      bus.pop          = pp;
      bus.err_clear    = clr;
      @(posedge clk);
      e.flags = ef;
      e.cnt   = ec;
      e.ovf   = eo;
      e.unf   = eu;
      q.push_back(e);
   endtask

   initial begin
      int wait_cyc;
      checks           = 0;
      failures         = 0;
      bReset           = 1'b1;
      bus.write_enable = 1'b0;
      bus.write_mask   = 4'h0;
      bus.flags_in     = 4'h0;
      bus.push         = 1'b0;
      bus.pop          = 1'b0;
      bus.err_clear    = 1'b0;

      // rst we mask    fin     psh pop clr | flags   cnt ovf unf
      step(1, 0, 4'h0, 4'h0,    0, 0, 0,   4'h0,    0, 0, 0);
      // masked write of low two bits
      step(0, 1, 4'h3, 4'hF,    0, 0, 0,   4'b0011, 0, 0, 0);
      step(0, 1, 4'hF, 4'b0101, 0, 0, 0,   4'b0101, 0, 0, 0);
      // push saves pre-write value
      step(0, 1, 4'hF, 4'b1010, 1, 0, 0,   4'b1010, 1, 0, 0);
      step(0, 0, 4'h0, 4'h0,    0, 1, 0,   4'b0101, 0, 0, 0);
      // fill the stack, fifth push overflows
      step(0, 1, 4'hF, 4'b0001, 1, 0, 0,   4'b0001, 1, 0, 0);
      step(0, 1, 4'hF, 4'b0010, 1, 0, 0,   4'b0010, 2, 0, 0);
      step(0, 1, 4'hF, 4'b0011, 1, 0, 0,   4'b0011, 3, 0, 0);
      step(0, 1, 4'hF, 4'b0100, 1, 0, 0,   4'b0100, 4, 0, 0);
      step(0, 1, 4'hF, 4'b0110, 1, 0, 0,   4'b0110, 4, 1, 0);
      // LIFO restore
      step(0, 0, 4'h0, 4'h0,    0, 1, 0,   4'b0011, 3, 1, 0);
      step(0, 0, 4'h0, 4'h0,    0, 1, 0,   4'b0010, 2, 1, 0);
      step(0, 0, 4'h0, 4'h0,    0, 1, 0,   4'b0001, 1, 1, 0);
      step(0, 0, 4'h0, 4'h0,    0, 1, 0,   4'b0101, 0, 1, 0);
      step(0, 0, 4'h0, 4'h0,    0, 0, 1,   4'b0101, 0, 0, 0);
      // empty pop: error, write still lands
      step(0, 1, 4'hF, 4'b1000, 0, 1, 0,   4'b1000, 0, 0, 1);
      step(0, 0, 4'h0, 4'h0,    0, 1, 1,   4'b1000, 0, 0, 1);
      step(0, 0, 4'h0, 4'h0,    0, 0, 1,   4'b1000, 0, 0, 0);
      // restore beats a simultaneous write
      step(0, 0, 4'h0, 4'h0,    1, 0, 0,   4'b1000, 1, 0, 0);
      step(0, 1, 4'hF, 4'b0111, 0, 1, 0,   4'b1000, 0, 0, 0);
      step(0, 1, 4'b0100, 4'hF, 0, 0, 0,   4'b1100, 0, 0, 0);
      // push+pop at count 2
      step(0, 0, 4'h0, 4'h0,    1, 0, 0,   4'b1100, 1, 0, 0);
      step(0, 0, 4'h0, 4'h0,    1, 0, 0,   4'b1100, 2, 0, 0);
      step(0, 1, 4'hF, 4'b0110, 1, 1, 0,   4'b0110, 2, 0, 0);
      // count 3 with overflow, then reset alongside push
      step(0, 0, 4'h0, 4'h0,    1, 0, 0,   4'b0110, 3, 0, 0);
      step(0, 0, 4'h0, 4'h0,    1, 0, 0,   4'b0110, 4, 0, 0);
      step(0, 0, 4'h0, 4'h0,    1, 0, 0,   4'b0110, 4, 1, 0);
      step(0, 0, 4'h0, 4'h0,    0, 1, 0,   4'b0110, 3, 1, 0);
      step(1, 1, 4'hF, 4'hF,    1, 0, 0,   4'h0,    0, 0, 0);
      // stacked entries are gone after reset
      step(0, 0, 4'h0, 4'h0,    0, 1, 0,   4'h0,    0, 0, 1);
      step(0, 0, 4'h0, 4'h0,    0, 0, 1,   4'h0,    0, 0, 0);

      @(negedge clk);
      bus.push      = 1'b0;
      bus.pop       = 1'b0;
      bus.err_clear = 1'b0;
      bus.write_enable = 1'b0;

      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain actual=%0d required=0",
                  q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
